regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
Parametrised multi-lane integer register file for the superscalar pipeline. It is the next generation after the single-lane combinational read/write-back register file.
- LANES lanes, each with two read ports and one write-back port.
- Write-to-read bypass and a busy-bit scoreboard for RAW hazard detection.
- A sequenced ecall handshake: captures a0..a7, waits for the environment, writes the return value to a0.
- Sits between decode (reads, issue) and write-back (writes).

Parameters:
LANES, 2, number of issue/write-back lanes (1..4)
XLEN, 64, register width in bits
NREG, 32, architectural register count; x0 hardwired to zero

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
rs1_addr  in  LANES*5  per-lane source 1 index (lane i at [5i+4:5i])
rs2_addr  in  LANES*5  per-lane source 2 index
rs1_data  out  LANES*XLEN  per-lane source 1 value, combinational
rs2_data  out  LANES*XLEN  per-lane source 2 value, combinational
rs1_busy  out  LANES  source 1 has a pending writer
rs2_busy  out  LANES  source 2 has a pending writer
issue_valid  in  LANES  lane issues an instruction this cycle
issue_rd  in  LANES*5  destination of the issued instruction
issue_wr  in  LANES  issued instruction writes rd
wb_valid  in  LANES  lane write-back valid (RegWrite)
wb_rd  in  LANES*5  write-back destination
wb_data  in  LANES*XLEN  write-back value
ecall_req  in  1  ecall reached write-back
ecall_args  out  8*XLEN  captured a0..a7 (a0 at LSB)
ecall_busy  out  1  ecall outstanding; pipeline must stall
ecall_done  in  1  environment finished ecall
ecall_ret  in  XLEN  value to write to a0
ac_ready  out  1  one-cycle pulse after ecall completion

Behaviour:
- Reset (async, reset_n low):
  - All registers clear to 0; all busy bits clear.
  - FSM goes to IDLE; ecall_args = 0, ecall_busy = 0, ac_ready = 0.
  - A reset asserted mid-ecall abandons the ecall and performs no a0 write.
- Writes:
  - Lane i writes on the rising edge when wb_valid[i] && wb_rd[i] != 0.
  - Writes to x0 are dropped; x0 always reads 0 and is never busy.
  - Two lanes writing the same rd in one cycle: the highest lane index wins.
- Reads:
  - Combinational. If any lane has wb_valid with a matching nonzero rd this cycle, the bypassed wb_data is returned; highest lane wins.
  - Otherwise the stored value is returned.
- Scoreboard:
  - Busy bit of rd sets on the edge where issue_valid[i] && issue_wr[i] && issue_rd[i] != 0.
  - Busy bit clears on the edge where a lane write-backs that rd.
  - Set and clear of the same register in one cycle: set wins, because the new writer is younger.
  - rsN_busy reflects the registered busy bit masked by same-cycle write-back: a bypassed operand is not busy.
  - Issue while ecall_busy is a protocol violation; the bench asserts on it.
- FSM, IDLE / WAIT / DONE:
  - IDLE: on ecall_req, capture x10..x17 into ecall_args, including same-cycle write-backs (bypassed values), then go to WAIT.
  - WAIT: ecall_busy = 1, ecall_args held. On ecall_done, x10 <= ecall_ret, then go to DONE.
    - If a lane writes x10 on the same edge, ecall_ret wins.
    - Other write-back lanes still commit.
    - ecall_req while in WAIT is ignored.
  - DONE: ac_ready = 1 for exactly one cycle, ecall_busy = 0, then go to IDLE.
    - ecall_req in DONE is not accepted; it is taken in IDLE next cycle.
- Latency:
  - Read: 0 cycles.
  - Write visible in storage: 1 edge.
  - ecall_done to ac_ready: 1 cycle.
  - Minimum ecall occupancy: 3 cycles (IDLE capture, WAIT, DONE).

Test Plan:
1. Reset, then LANES=2 with lane0 wb x5=0x1234 and lane1 wb x6=0xFFFF_FFFF_FFFF_FFFF -> same-cycle reads of x5 and x6 return the bypassed values; next cycle stored values match; x0 reads 0 after a wb x0=7.
2. Both lanes wb x9 (lane0 0xAA, lane1 0xBB) -> same-cycle read 0xBB; stored 0xBB.
3. Issue lane0 rd=x3 -> rs1_busy=1 for rs1=x3 next cycle. wb x3=0x55 -> busy=0 in that cycle (bypass) and clear after the edge. Issue x3 and wb x3 in the same cycle -> busy remains 1.
4. Load x10..x17 with 1..8, assert ecall_req -> ecall_args = {8,...,1} and ecall_busy=1. Hold 5 cycles, then ecall_done with ecall_ret=0x42 -> x10=0x42; ac_ready pulses exactly 1 cycle; ecall_busy falls.
5. In WAIT, assert ecall_done together with lane0 wb x10=0x99 and lane1 wb x11=0x77 -> x10=0x42, x11=0x77.
6. Assert reset_n low in WAIT -> everything zero immediately (asynchronous); no ac_ready pulse; a later ecall_done is ignored.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-lane register file with write bypass, busy-bit scoreboard and ecall handshake
module regfile_scoreboard #(
  parameter int LANES = 2,
  parameter int XLEN  = 64,
  parameter int NREG  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [LANES*5-1:0]    rs1_addr,
  input  logic [LANES*5-1:0]    rs2_addr,
  output logic [LANES*XLEN-1:0] rs1_data,
  output logic [LANES*XLEN-1:0] rs2_data,
  output logic [LANES-1:0]      rs1_busy,
  output logic [LANES-1:0]      rs2_busy,
  input  logic [LANES-1:0]      issue_valid,
  input  logic [LANES*5-1:0]    issue_rd,
  input  logic [LANES-1:0]      issue_wr,
  input  logic [LANES-1:0]      wb_valid,
  input  logic [LANES*5-1:0]    wb_rd,
  input  logic [LANES*XLEN-1:0] wb_data,
  input  logic                  ecall_req,
  output logic [8*XLEN-1:0]     ecall_args,
  output logic                  ecall_busy,
  input  logic                  ecall_done,
  input  logic [XLEN-1:0]       ecall_ret,
  output logic                  ac_ready
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t            state_q, state_d;
  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [8*XLEN-1:0] args_q, args_d;
  function automatic logic byp_hit(input logic [4:0] a);
    byp_hit = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (wb_valid[i] && wb_rd[5*i +: 5] == a && a != 5'd0) byp_hit = 1'b1;
  endfunction
  function automatic logic [XLEN-1:0] rd_val(input logic [4:0] a);
    rd_val = regs_q[a];
    for (int i = 0; i < LANES; i++)
      if (wb_valid[i] && wb_rd[5*i +: 5] == a && a != 5'd0) rd_val = wb_data[XLEN*i +: XLEN];
  endfunction
  // State register: all storage, scoreboard, captured args and FSM state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      regs_q  <= '{default: '0};
      busy_q  <= '0;
      args_q  <= '0;
      state_q <= S_IDLE;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      args_q  <= args_d;
      state_q <= state_d;
    end
  // Read ports: bypass same-cycle write-back (highest lane wins); bypassed operands are not busy
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = '0;
    rs2_busy = '0;
    for (int i = 0; i < LANES; i++) begin
      rs1_data[XLEN*i +: XLEN] = rd_val(rs1_addr[5*i +: 5]);
      rs2_data[XLEN*i +: XLEN] = rd_val(rs2_addr[5*i +: 5]);
      rs1_busy[i] = busy_q[rs1_addr[5*i +: 5]] && !byp_hit(rs1_addr[5*i +: 5]);
      rs2_busy[i] = busy_q[rs2_addr[5*i +: 5]] && !byp_hit(rs2_addr[5*i +: 5]);
    end
  end
  // Write-back, ecall return (overrides any lane writing x10), and ecall argument capture
  always_comb begin
    regs_d = regs_q;
    args_d = args_q;
    for (int i = 0; i < LANES; i++)
      if (wb_valid[i]) regs_d[wb_rd[5*i +: 5]] = wb_data[XLEN*i +: XLEN];
    if (state_q == S_WAIT && ecall_done) regs_d[10] = ecall_ret;
    regs_d[0] = '0;
    if (state_q == S_IDLE && ecall_req)
      for (int k = 0; k < 8; k++) args_d[XLEN*k +: XLEN] = rd_val(5'(10 + k));
  end
  // Scoreboard: write-back clears, issue sets afterwards so the younger writer wins
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < LANES; i++)
      if (wb_valid[i]) busy_d[wb_rd[5*i +: 5]] = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (issue_valid[i] && issue_wr[i]) busy_d[issue_rd[5*i +: 5]] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // Next-state logic for the ecall handshake
  always_comb
    state_d = state_q == S_IDLE ? (ecall_req ? S_WAIT : S_IDLE) :
              state_q == S_WAIT ? (ecall_done ? S_DONE : S_WAIT) : S_IDLE;
  // Handshake outputs decoded from the registered state
  always_comb begin
    ecall_busy = state_q == S_WAIT;
    ac_ready   = state_q == S_DONE;
    ecall_args = args_q;
  end
endmodule
